uart_tx_arbiter: RTL and testbench

- Shares one UART byte transmitter among NUM_REQ byte-stream requesters using round-robin arbitration, packet-at-a-time.
- Latches each winner's frame configuration (parity sense, stop bits) and drives the transmitter's enable, data and config inputs.
- Paces one byte per completed frame.
- Sits between the system-side byte sources and the UART Tx block.

---
 rtl/uart_tx_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART byte transmitter among NUM_REQ byte-stream requesters.
// Arbitration is round-robin and packet-at-a-time. A grant lasts until the
// requester's last byte, until MAX_BURST bytes have been sent, or until the
// owner leaves req_valid low for STALL_TIMEOUT clocks. The winner's frame
// configuration is latched at grant time. One byte is issued per completed
// frame.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[i]        requester i has a byte available
//   req_data[8i+7:8i]   byte offered by requester i
//   req_last[i]         offered byte ends requester i's packet
//   req_odd_parity[i]   requester i wants odd parity
//   req_two_stop[i]     requester i wants two stop bits
//   req_ready[i]        combinational accept strobe (one-hot or zero)
//   tx_busy             transmitter cannot take a byte
//   tx_done             one-cycle pulse at the end of a transmitted frame
//   tx_en               registered one-cycle start pulse to the transmitter
//   tx_data             registered byte to the transmitter
//   tx_odd_parity       latched parity sense of the current/last owner
//   tx_two_stop         latched stop-bit count of the current/last owner
//   grant_valid         a requester currently owns the transmitter
//   grant_id            index of the owning requester
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 4,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ-1:0]         req_odd_parity,
  input  logic [NUM_REQ-1:0]         req_two_stop,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       tx_en,
  output logic [7:0]                 tx_data,
  output logic                       tx_odd_parity,
  output logic                       tx_two_stop,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  // The stall counter is compared one below the timeout so the grant drops
  // exactly STALL_TIMEOUT clocks after the owner is first seen idle in ISSUE.
  localparam logic [9:0] STALL_LIMIT = 10'(STALL_TIMEOUT - 1);
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  // Registered state
  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_grant_id;
  logic            r_grant_valid;
  logic [3:0]      r_burst_cnt;
  logic [9:0]      r_stall_cnt;
  logic            r_last;
  logic            r_tx_en;
  logic [7:0]      r_tx_data;
  logic            r_tx_odd;
  logic            r_tx_two;

  // Next-state values
  state_t          w_state_nxt;
  logic [ID_W-1:0] w_rr_ptr_nxt;
  logic [ID_W-1:0] w_grant_id_nxt;
  logic            w_grant_valid_nxt;
  logic [3:0]      w_burst_cnt_nxt;
  logic [9:0]      w_stall_cnt_nxt;
  logic            w_last_nxt;
  logic            w_tx_en_nxt;
  logic [7:0]      w_tx_data_nxt;
  logic            w_tx_odd_nxt;
  logic            w_tx_two_nxt;

  // Helpers
  logic [7:0]         w_req_byte [NUM_REQ];
  logic [ID_W-1:0]    w_winner;
  logic               w_owner_valid;
  logic [NUM_REQ-1:0] w_owner_onehot;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_byte[gi] = req_data[8*gi +: 8];
  end

  assign w_owner_valid  = req_valid[r_grant_id];
  assign w_owner_onehot = NUM_REQ'(1) << r_grant_id;

  // Round-robin pick: scan from rr_ptr+1 upward with wrap. Walking the
  // offsets from farthest to nearest lets the nearest hit overwrite the rest,
  // so the first requester after the pointer wins without a loop exit.
  always_comb begin
    w_winner = r_rr_ptr;
    for (int off = NUM_REQ; off >= 1; off--) begin
      int idx;
      idx = int'(r_rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx[ID_W-1:0]]) w_winner = idx[ID_W-1:0];
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_nxt       = r_state;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = r_grant_valid;
    w_burst_cnt_nxt   = r_burst_cnt;
    w_stall_cnt_nxt   = r_stall_cnt;
    w_last_nxt        = r_last;
    w_tx_en_nxt       = 1'b0;
    w_tx_data_nxt     = r_tx_data;
    w_tx_odd_nxt      = r_tx_odd;
    w_tx_two_nxt      = r_tx_two;
    req_ready         = '0;

    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_grant_id_nxt    = w_winner;
          w_grant_valid_nxt = 1'b1;
          w_tx_odd_nxt      = req_odd_parity[w_winner];
          w_tx_two_nxt      = req_two_stop[w_winner];
          w_burst_cnt_nxt   = '0;
          w_stall_cnt_nxt   = '0;
          w_state_nxt       = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (w_owner_valid) begin
          // A busy transmitter holds the grant without counting as a stall.
          if (!tx_busy) begin
            req_ready       = w_owner_onehot;
            w_tx_en_nxt     = 1'b1;
            w_tx_data_nxt   = w_req_byte[r_grant_id];
            w_burst_cnt_nxt = r_burst_cnt + 4'd1;
            w_last_nxt      = req_last[r_grant_id];
            w_stall_cnt_nxt = '0;
            w_state_nxt     = S_WAIT_DONE;
          end
        end else if (r_stall_cnt == STALL_LIMIT) begin
          w_rr_ptr_nxt      = r_grant_id;
          w_grant_valid_nxt = 1'b0;
          w_stall_cnt_nxt   = '0;
          w_state_nxt       = S_IDLE;
        end else begin
          w_stall_cnt_nxt = r_stall_cnt + 10'd1;
        end
      end

      S_WAIT_DONE: begin
        if (tx_done) begin
          if (r_last || (r_burst_cnt == BURST_LIMIT)) begin
            w_rr_ptr_nxt      = r_grant_id;
            w_grant_valid_nxt = 1'b0;
            w_state_nxt       = S_IDLE;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= ID_W'(NUM_REQ - 1);
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_burst_cnt   <= '0;
      r_stall_cnt   <= '0;
      r_last        <= 1'b0;
      r_tx_en       <= 1'b0;
      r_tx_data     <= '0;
      r_tx_odd      <= 1'b0;
      r_tx_two      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_burst_cnt   <= w_burst_cnt_nxt;
      r_stall_cnt   <= w_stall_cnt_nxt;
      r_last        <= w_last_nxt;
      r_tx_en       <= w_tx_en_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_odd      <= w_tx_odd_nxt;
      r_tx_two      <= w_tx_two_nxt;
    end
  end

  assign tx_en         = r_tx_en;
  assign tx_data       = r_tx_data;
  assign tx_odd_parity = r_tx_odd;
  assign tx_two_stop   = r_tx_two;
  assign grant_valid   = r_grant_valid;
  assign grant_id      = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. Requesters are modelled as byte
// FIFOs, the transmitter as a fixed-latency tx_done generator. Every byte the
// arbiter should issue is pushed to a scoreboard when the stimulus is loaded
// and compared (owner, byte, frame config) on each tx_en pulse. A vector table
// covers first-grant arbitration from IDLE; hand sequences cover bursts,
// stalls, busy hold-off and reset.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int MAX_BURST     = 4;
  localparam int STALL_TIMEOUT = 12;
  localparam int DONE_LAT      = 3;
  localparam int SRC_DEPTH     = 16;
  localparam int NUM_VECS      = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_odd_parity;
  logic [NUM_REQ-1:0]   req_two_stop;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_busy = 1'b0;
  logic                 tx_done = 1'b0;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 tx_odd_parity;
  logic                 tx_two_stop;
  logic                 grant_valid;
  logic [1:0]           grant_id;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .MAX_BURST    (MAX_BURST),
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_odd_parity(req_odd_parity),
    .req_two_stop  (req_two_stop),
    .req_ready     (req_ready),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_en         (tx_en),
    .tx_data       (tx_data),
    .tx_odd_parity (tx_odd_parity),
    .tx_two_stop   (tx_two_stop),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       odd;
    logic       two;
  } sb_t;

  sb_t sb_q[$];

  task automatic expect_tx(input int id, input logic [7:0] data, input logic odd, input logic two);
    sb_t e;
    e.id   = 2'(id);
    e.data = data;
    e.odd  = odd;
    e.two  = two;
    sb_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Requester model: one circular byte FIFO per requester, {last, data}.
  // The main sequence pushes (tail), the driver pops on accept (head).
  // ---------------------------------------------------------------------------
  logic [8:0]         src_mem  [NUM_REQ][SRC_DEPTH];
  int                 src_head [NUM_REQ];
  int                 src_tail [NUM_REQ];
  logic [NUM_REQ-1:0] cfg_odd = '0;
  logic [NUM_REQ-1:0] cfg_two = '0;

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_head[i] < src_tail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_head[i] % SRC_DEPTH][7:0];
        req_last[i]        = src_mem[i][src_head[i] % SRC_DEPTH][8];
      end
    end
    req_odd_parity = cfg_odd;
    req_two_stop   = cfg_two;
  end

  task automatic push_byte(input int id, input logic [7:0] data, input logic last);
    src_mem[id][src_tail[id] % SRC_DEPTH] = {last, data};
    src_tail[id] = src_tail[id] + 1;
  endtask

  task automatic clear_src(input int id);
    src_tail[id] = src_head[id];
  endtask

  // ---------------------------------------------------------------------------
  // Monitor (negedge): samples strobes for the driver and runs the scoreboard.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] ready_s = '0;
  logic               ten_s = 1'b0;
  int                 ten_count = 0;

  always @(negedge clk) begin
    ready_s = req_ready;
    ten_s   = tx_en;
    if (rst_n) begin
      if (req_ready != '0) begin
        check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        check("ready_owner", req_ready, grant_valid ? (4'b0001 << grant_id) : 4'b0000);
        check("ready_without_valid", req_ready & ~req_valid, 0);
      end
      if (tx_en) begin
        ten_count++;
        if (sb_q.size() == 0) begin
          check("unexpected_tx_en", tx_en, 0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("sb_grant_valid", grant_valid, 1);
          check("sb_grant_id", grant_id, e.id);
          check("sb_tx_data", tx_data, e.data);
          check("sb_tx_odd_parity", tx_odd_parity, e.odd);
          check("sb_tx_two_stop", tx_two_stop, e.two);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver (posedge + 1): pops accepted bytes and models the transmitter.
  // ---------------------------------------------------------------------------
  int   done_cnt = 0;
  logic auto_done = 1'b1;

  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (!rst_n) begin
      done_cnt = 0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ready_s[i] && (src_head[i] < src_tail[i])) src_head[i] = src_head[i] + 1;
      end
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) tx_done = 1'b1;
      end
      if (ten_s && auto_done) done_cnt = DONE_LAT;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing helpers. The main sequence acts at posedge + 2.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) clear_src(i);
    sb_q.delete();
    tx_busy   = 1'b0;
    auto_done = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((grant_valid || (sb_q.size() != 0)) && (n < budget)) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, 32'(n >= budget), 0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_done && (n < budget));
    check({name, "_done_timeout"}, tx_done, 1);
  endtask

  task automatic wait_tx_en(input string name, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_en && (n < budget));
    check({name, "_tx_en_timeout"}, tx_en, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Arbitration vectors. Each one starts from IDLE with the round-robin
  // pointer left at the previous winner (3 after reset); the winner's config
  // is set to {odd, two} and everyone else's to the inverse.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] mask;
    logic       odd;
    logic       two;
    int         exp_id;
  } vec_t;

  vec_t vecs [NUM_VECS];

  initial begin
    int c0;
    int n;
    int bad;

    vecs[0] = '{4'b0001, 1'b1, 1'b0, 0};  // ptr 3 -> 0
    vecs[1] = '{4'b0001, 1'b0, 1'b1, 0};  // ptr 0, only 0 asks -> 0 again
    vecs[2] = '{4'b1111, 1'b1, 1'b1, 1};  // ptr 0 -> 1
    vecs[3] = '{4'b1001, 1'b0, 1'b0, 3};  // ptr 1 -> skip 2 -> 3
    vecs[4] = '{4'b1001, 1'b1, 1'b0, 0};  // ptr 3 -> wrap to 0
    vecs[5] = '{4'b0100, 1'b0, 1'b1, 2};  // ptr 0 -> 2
    vecs[6] = '{4'b0110, 1'b1, 1'b1, 1};  // ptr 2 -> 3,0 empty -> 1
    vecs[7] = '{4'b1110, 1'b0, 1'b0, 2};  // ptr 1 -> 2
    vecs[8] = '{4'b1011, 1'b1, 1'b0, 3};  // ptr 2 -> 3
    vecs[9] = '{4'b0011, 1'b0, 1'b1, 0};  // ptr 3 -> 0

    // Reset state
    #1;
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_cfg", {tx_odd_parity, tx_two_stop}, 0);
    check("rst_req_ready", req_ready, 0);
    apply_reset();

    // Table-driven first-grant arbitration
    for (int k = 0; k < NUM_VECS; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cfg_odd[i] = (i == vecs[k].exp_id) ? vecs[k].odd : ~vecs[k].odd;
        cfg_two[i] = (i == vecs[k].exp_id) ? vecs[k].two : ~vecs[k].two;
        if (vecs[k].mask[i]) push_byte(i, 8'(8'h10 + k), 1'b1);
      end
      expect_tx(vecs[k].exp_id, 8'(8'h10 + k), vecs[k].odd, vecs[k].two);
      tick();
      check($sformatf("vec%0d_grant_valid", k), grant_valid, 1);
      check($sformatf("vec%0d_grant_id", k), grant_id, vecs[k].exp_id);
      check($sformatf("vec%0d_cfg", k), {tx_odd_parity, tx_two_stop}, {vecs[k].odd, vecs[k].two});
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i != vecs[k].exp_id) clear_src(i);
      end
      wait_idle($sformatf("vec%0d", k), 100);
    end

    // A: single requester, three-byte packet, odd parity
    apply_reset();
    cfg_odd[0] = 1'b1;
    cfg_two[0] = 1'b0;
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h43, 1'b1);
    expect_tx(0, 8'h41, 1'b1, 1'b0);
    expect_tx(0, 8'h42, 1'b1, 1'b0);
    expect_tx(0, 8'h43, 1'b1, 1'b0);
    c0 = ten_count;
    tick();
    check("A_grant_valid", grant_valid, 1);
    check("A_grant_id", grant_id, 0);
    cfg_odd[0] = 1'b0;  // must not affect the current grant
    #1;
    check("A_req_ready", req_ready, 4'b0001);
    tick();
    check("A_tx_en_after_ready", tx_en, 1);
    wait_done("A1", 40);
    wait_done("A2", 40);
    wait_done("A3", 40);
    check("A_held_until_last_done", grant_valid, 1);
    tick();
    check("A_release", grant_valid, 0);
    check("A_tx_en_count", ten_count - c0, 3);
    wait_idle("A", 50);

    // B: all four requesting single-byte packets -> 0,1,2,3,0,1
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      cfg_odd[i] = i[0];
      cfg_two[i] = i[1];
    end
    push_byte(0, 8'hA0, 1'b1);
    push_byte(0, 8'hA4, 1'b1);
    push_byte(1, 8'hA1, 1'b1);
    push_byte(1, 8'hA5, 1'b1);
    push_byte(2, 8'hA2, 1'b1);
    push_byte(3, 8'hA3, 1'b1);
    expect_tx(0, 8'hA0, 1'b0, 1'b0);
    expect_tx(1, 8'hA1, 1'b1, 1'b0);
    expect_tx(2, 8'hA2, 1'b0, 1'b1);
    expect_tx(3, 8'hA3, 1'b1, 1'b1);
    expect_tx(0, 8'hA4, 1'b0, 1'b0);
    expect_tx(1, 8'hA5, 1'b1, 1'b0);
    wait_idle("B", 300);

    // C: req2 streams 10 bytes without last, req1 joins -> burst limit
    apply_reset();
    cfg_odd = 4'b0010;
    cfg_two = 4'b0110;
    for (int b = 0; b < 10; b++) push_byte(2, 8'(8'hC0 + b), 1'b0);
    for (int b = 0; b < 4; b++) expect_tx(2, 8'(8'hC0 + b), 1'b0, 1'b1);
    expect_tx(1, 8'hB1, 1'b1, 1'b1);
    for (int b = 4; b < 10; b++) expect_tx(2, 8'(8'hC0 + b), 1'b0, 1'b1);
    tick();
    check("C_grant_id", grant_id, 2);
    push_byte(1, 8'hB1, 1'b1);
    wait_idle("C", 600);

    // F: reset while waiting for a frame to finish (pointer is 2 here)
    cfg_odd[2] = 1'b1;
    cfg_two[2] = 1'b1;
    auto_done  = 1'b0;
    push_byte(2, 8'h5A, 1'b1);
    expect_tx(2, 8'h5A, 1'b1, 1'b1);
    wait_tx_en("F", 20);
    rst_n = 1'b0;
    #1;
    check("F_rst_tx_en", tx_en, 0);
    check("F_rst_tx_data", tx_data, 0);
    check("F_rst_tx_cfg", {tx_odd_parity, tx_two_stop}, 0);
    check("F_rst_grant_valid", grant_valid, 0);
    check("F_rst_grant_id", grant_id, 0);
    check("F_rst_req_ready", req_ready, 0);
    for (int i = 0; i < NUM_REQ; i++) clear_src(i);
    sb_q.delete();
    auto_done = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cfg_odd = 4'b1000;
    cfg_two = 4'b0000;
    push_byte(1, 8'h61, 1'b1);
    push_byte(3, 8'h63, 1'b1);
    expect_tx(1, 8'h61, 1'b0, 1'b0);
    expect_tx(3, 8'h63, 1'b1, 1'b0);
    tick();
    check("F_first_winner_after_reset", grant_id, 1);
    wait_idle("F", 100);

    // D: req3 sends one byte then stalls -> revoked after STALL_TIMEOUT
    cfg_odd[3] = 1'b0;
    cfg_two[3] = 1'b1;
    push_byte(3, 8'hD3, 1'b0);
    expect_tx(3, 8'hD3, 1'b0, 1'b1);
    c0 = ten_count;
    wait_done("D", 40);
    tick();
    n = 0;
    while (grant_valid && (n < STALL_TIMEOUT + 20)) begin
      tick();
      n++;
    end
    check("D_stall_revoke_cycles", n, STALL_TIMEOUT);
    check("D_tx_en_count", ten_count - c0, 1);
    wait_idle("D", 20);

    // E: tx_busy holds off the accept for 20 cycles without a stall revoke
    tx_busy    = 1'b1;
    cfg_odd[0] = 1'b1;
    cfg_two[0] = 1'b1;
    push_byte(0, 8'hE0, 1'b1);
    expect_tx(0, 8'hE0, 1'b1, 1'b1);
    tick();
    check("E_grant_id", grant_id, 0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if ((req_ready != '0) || !grant_valid || tx_en) bad++;
      tick();
    end
    check("E_busy_hold", bad, 0);
    tx_busy = 1'b0;
    #1;
    check("E_ready_after_busy", req_ready, 4'b0001);
    tick();
    check("E_tx_en_after_busy", tx_en, 1);
    wait_idle("E", 50);

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
